dc_wr_fifo: RTL and testbench
=============================

// Module: dc_wr_fifo
// PURPOSE
//  Store buffer between write-back and dcache write port. Write-back pushes retired stores
//  (addr/size/data); the dcache drains the head entry and pops it with mem_wr_done. Supplies
//  wr_fifo_empty/wr_fifo_to_be_full to the dcache arbiter, and mem_conflict for loads that
//  overlap a buffered store at 16B-line granularity, so the load waits for the drain.
// PARAMETERS
//  DEPTH   4   entries; power of two, >=2
//  PTR_W   2   log2(DEPTH)
// PORTS
//  clk                 in   1   clock, rising edge
//  rst                 in   1   reset, asynchronous, active-high
//  wb_push             in   1   write-back has a valid store this cycle
//  wb_addr             in   32  store virtual byte address
//  wb_size             in   2   0=1B 1=2B 2=4B 3=8B
//  wb_data             in   64  store data, right-aligned
//  mem_wr_done         in   1   dcache finished head store; pop
//  mem_rd_addr         in   32  pending load address (read-operand stage)
//  mem_rd_size         in   2   pending load size, encoding as wb_size
//  mem_wr_addr         out  32  head entry address
//  mem_wr_size         out  2   head entry size
//  mem_wr_data         out  64  head entry data
//  wr_fifo_empty       out  1   no valid entries
//  wr_fifo_to_be_full  out  1   count >= DEPTH-1; write-back must stall
//  mem_conflict        out  1   load lines overlap a valid entry's lines
//  wr_fifo_ovf         out  1   sticky: push attempted while full
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-drain): wr_ptr=rd_ptr=count=0, all valid bits 0,
//    wr_fifo_ovf=0. Outputs: wr_fifo_empty=1, wr_fifo_to_be_full=0, mem_conflict=0,
//    mem_wr_* = 0 (head fields gated by valid). Storage data need not be reset.
//  - Push: wb_push & (count<DEPTH | mem_wr_done) writes entry[wr_ptr], sets valid, wr_ptr+1
//    (wraps mod DEPTH). Push at count==DEPTH without pop: entry dropped, wr_fifo_ovf set.
//  - Pop: mem_wr_done & !wr_fifo_empty clears valid[rd_ptr], rd_ptr+1 (wraps). mem_wr_done
//    while empty ignored (no pointer/count change).
//  - Simultaneous push+pop: count unchanged, both pointers advance; legal at count==DEPTH.
//  - Latency: pushed store visible on mem_wr_* next cycle if FIFO was empty (no bypass).
//    mem_wr_* is pure combinational readout of entry[rd_ptr]; stable until pop.
//  - count: PTR_W+1 bits, 0..DEPTH; empty = (count==0); to_be_full = (count>=DEPTH-1),
//    both decoded from registered count (no same-cycle push/pop term).
//  - mem_conflict (combinational): load line set {L0=rd_addr[31:4], L1=(rd_addr+bytes-1)[31:4]}
//    vs each valid entry's {S0,S1} computed the same way; conflict if any of L0/L1 equals
//    S0 or S1 of a valid entry. bytes-1 = (1<<size)-1; add is 32-bit, carry-out dropped
//    (0xFFFFFFFF wrap-around compares as line 0). Entry pushed this cycle not included;
//    entry popped this cycle still included. Store end-line S1 precomputed at push, stored.
//  - wr_fifo_ovf cleared only by rst.
// STRUCTURE
//  - Shared package: size encoding constants (SZ_1B..SZ_8B), LINE_OFS_W=4.
//  - Sub-module dc_wr_fifo_line_cmp: one instance per entry; inputs L0,L1,S0,S1,valid ->
//    hit; top ORs DEPTH hits into mem_conflict. Storage, pointers, count in top.
// TESTING
//  - Reset mid-operation: 3 entries, assert rst -> empty=1, to_be_full=0, conflict=0 same cycle.
//  - Fill: push 0x1000/0x1010/0x1020 -> to_be_full=1 after 3rd; 4th push -> count=4; 5th push
//    without pop -> dropped, wr_fifo_ovf=1, head still 0x1000.
//  - Push+pop at full: head 0x1000 popped, new 0x2000 accepted; count stays 4, head=0x1010.
//  - Ordering/wrap: 10 push/pop pairs -> mem_wr_addr sequence equals push order across wraps.
//  - Conflict: store 0x200C size 3 (lines 0x200,0x201) -> load 0x2010 size 0 conflict=1;
//    load 0x2020 conflict=0; after pop conflict=0 for 0x2010.
//  - Edge: store 0xFFFFFFFC size 3 -> load 0x00000000 size 0 conflict=1; mem_wr_done on empty
//    -> count stays 0, empty=1.

Source files
------------

// File: rtl/dc_wr_fifo_pkg.sv
// Shared constants for the dcache store buffer: size encoding, line geometry
// and the end-line helper used at push time.
package dc_wr_fifo_pkg;

   localparam int FIFO_DEPTH = 4;
   localparam int FIFO_PTR_W = 2;

   localparam logic [1:0] SZ_1B = 2'd0;
   localparam logic [1:0] SZ_2B = 2'd1;
   localparam logic [1:0] SZ_4B = 2'd2;
   localparam logic [1:0] SZ_8B = 2'd3;

   localparam int LINE_OFS_W = 4;
   localparam int LINE_W     = 32 - LINE_OFS_W;

   // Line index of the last byte touched; the 32-bit add wraps past 0xFFFFFFFF.
   function automatic logic [LINE_W-1:0] end_line(input logic [31:0] addr,
                                                  input logic [1:0]  size);
      logic [31:0] w_last;
      w_last = addr + ((32'd1 << size) - 32'd1);
      return w_last[31:LINE_OFS_W];
   endfunction

endpackage

// File: rtl/dc_wr_fifo_if.sv
// Bus bundle between write-back, the store buffer and the dcache write/read ports.
// Handshake: a store transfers on any cycle wb_push=1 while the producer honours
// wr_fifo_to_be_full; the head transfers on the cycle mem_wr_done=1 with wr_fifo_empty=0.
interface dc_wr_fifo_if #(
   parameter int PTR_W = 2
);
   logic              wb_push;
   logic [31:0]       wb_addr;
   logic [1:0]        wb_size;
   logic [63:0]       wb_data;
   logic              mem_wr_done;
   logic [31:0]       mem_rd_addr;
   logic [1:0]        mem_rd_size;
   logic [31:0]       mem_wr_addr;
   logic [1:0]        mem_wr_size;
   logic [63:0]       mem_wr_data;
   logic              wr_fifo_empty;
   logic              wr_fifo_to_be_full;
   logic              mem_conflict;
   logic              wr_fifo_ovf;
   logic [PTR_W:0]    dbg_count;

   modport slave (
      input  wb_push, wb_addr, wb_size, wb_data, mem_wr_done, mem_rd_addr, mem_rd_size,
      output mem_wr_addr, mem_wr_size, mem_wr_data, wr_fifo_empty, wr_fifo_to_be_full,
             mem_conflict, wr_fifo_ovf, dbg_count
   );

   modport master (
      output wb_push, wb_addr, wb_size, wb_data, mem_wr_done, mem_rd_addr, mem_rd_size,
      input  mem_wr_addr, mem_wr_size, mem_wr_data, wr_fifo_empty, wr_fifo_to_be_full,
             mem_conflict, wr_fifo_ovf, dbg_count
   );

endinterface

// File: rtl/dc_wr_fifo_line_cmp.sv
// Per-entry line overlap check: a load's start/end lines against one stored
// store's start/end lines.
module dc_wr_fifo_line_cmp
   import dc_wr_fifo_pkg::*;
(
   input  logic [LINE_W-1:0] i_l0,
   input  logic [LINE_W-1:0] i_l1,
   input  logic [LINE_W-1:0] i_s0,
   input  logic [LINE_W-1:0] i_s1,
   input  logic              i_valid,
   output logic              o_hit
);

   logic w_any_eq;

   assign w_any_eq = (i_l0 == i_s0) | (i_l0 == i_s1) | (i_l1 == i_s0) | (i_l1 == i_s1);
   assign o_hit    = i_valid & w_any_eq;

endmodule

// File: rtl/dc_wr_fifo.sv
// Store buffer between write-back and the dcache write port, with a line-granular
// load conflict detector over all buffered stores.
module dc_wr_fifo
   import dc_wr_fifo_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH,
   parameter int PTR_W = FIFO_PTR_W
) (
   input logic          clk,
   input logic          rst,
   dc_wr_fifo_if.slave  bus
);

   localparam logic [PTR_W:0]   C_FULL    = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   C_ALMOST  = (PTR_W+1)'(DEPTH-1);
   localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

   logic [31:0]       r_addr [DEPTH];
   logic [1:0]        r_size [DEPTH];
   logic [63:0]       r_data [DEPTH];
   logic [LINE_W-1:0] r_s1   [DEPTH];
   logic [DEPTH-1:0]  r_valid;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;
   logic              r_ovf;

   logic              w_empty;
   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic              w_head_vld;
   logic [DEPTH-1:0]  w_valid_nxt;
   logic [LINE_W-1:0] w_l0;
   logic [LINE_W-1:0] w_l1;
   logic [DEPTH-1:0]  w_hit;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == C_FULL);
   assign w_pop   = bus.mem_wr_done & ~w_empty;
   // At full a push is only legal when the head drains in the same cycle.
   assign w_push  = bus.wb_push & (~w_full | bus.mem_wr_done);

   always_comb begin
      w_valid_nxt = r_valid;
      if (w_pop) begin
         w_valid_nxt[r_rd_ptr] = 1'b0;
      end
      if (w_push) begin
         w_valid_nxt[r_wr_ptr] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_valid <= w_valid_nxt;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (bus.wb_push & w_full & ~bus.mem_wr_done) begin
            r_ovf <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wr_ptr] <= bus.wb_addr;
         r_size[r_wr_ptr] <= bus.wb_size;
         r_data[r_wr_ptr] <= bus.wb_data;
         r_s1[r_wr_ptr]   <= end_line(bus.wb_addr, bus.wb_size);
      end
   end

   assign w_head_vld             = r_valid[r_rd_ptr];
   assign bus.mem_wr_addr        = w_head_vld ? r_addr[r_rd_ptr] : '0;
   assign bus.mem_wr_size        = w_head_vld ? r_size[r_rd_ptr] : '0;
   assign bus.mem_wr_data        = w_head_vld ? r_data[r_rd_ptr] : '0;
   assign bus.wr_fifo_empty      = w_empty;
   assign bus.wr_fifo_to_be_full = (r_count >= C_ALMOST);
   assign bus.wr_fifo_ovf        = r_ovf;
   assign bus.dbg_count          = r_count;

   assign w_l0 = bus.mem_rd_addr[31:LINE_OFS_W];
   assign w_l1 = end_line(bus.mem_rd_addr, bus.mem_rd_size);

   for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
      dc_wr_fifo_line_cmp u_cmp (
         .i_l0    (w_l0),
         .i_l1    (w_l1),
         .i_s0    (r_addr[g][31:LINE_OFS_W]),
         .i_s1    (r_s1[g]),
         .i_valid (r_valid[g]),
         .o_hit   (w_hit[g])
      );
   end

   assign bus.mem_conflict = |w_hit;

endmodule

// File: tb/tb_dc_wr_fifo.sv
// Self-checking bench for dc_wr_fifo: directed scenarios plus randomized traffic
// against a queue-based model of the store buffer.
module tb_dc_wr_fifo;
   import dc_wr_fifo_pkg::*;

   localparam int DEPTH = FIFO_DEPTH;
   localparam int EW    = 98;
   localparam int VW    = 104;

   logic clk;
   logic rst;

   dc_wr_fifo_if #(.PTR_W(FIFO_PTR_W)) bus ();

   dc_wr_fifo #(.DEPTH(DEPTH), .PTR_W(FIFO_PTR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Model: entries {addr[31:0], size[1:0], data[63:0]} oldest first.
   logic [EW-1:0] exp_q[$];
   bit            exp_ovf;
   int            n_total;
   int            n_pass;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [VW-1:0] exp_vec();
      logic [31:0] a;
      logic [1:0]  s;
      logic [63:0] d;
      logic [2:0]  c;
      a = '0; s = '0; d = '0;
      if (exp_q.size() != 0) begin
         a = exp_q[0][97:66];
         s = exp_q[0][65:64];
         d = exp_q[0][63:0];
      end
      c = 3'(exp_q.size());
      return {exp_q.size() == 0, exp_q.size() >= DEPTH - 1, exp_ovf, c, a, s, d};
   endfunction

   function automatic logic [VW-1:0] obs_vec();
      return {bus.wr_fifo_empty, bus.wr_fifo_to_be_full, bus.wr_fifo_ovf, bus.dbg_count,
              bus.mem_wr_addr, bus.mem_wr_size, bus.mem_wr_data};
   endfunction

   function automatic logic model_conflict(input logic [31:0] la, input logic [1:0] ls);
      logic [31:0] le;
      logic [31:0] sa;
      logic [31:0] se;
      logic        hit;
      hit = 1'b0;
      le  = la + (32'd1 << ls) - 32'd1;
      foreach (exp_q[i]) begin
         sa = exp_q[i][97:66];
         se = sa + (32'd1 << exp_q[i][65:64]) - 32'd1;
         if ((la >> 4) == (sa >> 4) || (la >> 4) == (se >> 4) ||
             (le >> 4) == (sa >> 4) || (le >> 4) == (se >> 4)) hit = 1'b1;
      end
      return hit;
   endfunction

   task automatic idle_inputs();
      bus.wb_push     = 1'b0;
      bus.wb_addr     = '0;
      bus.wb_size     = '0;
      bus.wb_data     = '0;
      bus.mem_wr_done = 1'b0;
   endtask

   // One clock: drive, take the edge, update the model the way the FIFO should.
   task automatic step(input logic push, input logic [31:0] a, input logic [1:0] s,
                       input logic [63:0] d, input logic done);
      bit do_pop;
      bit do_push;
      bus.wb_push     = push;
      bus.wb_addr     = a;
      bus.wb_size     = s;
      bus.wb_data     = d;
      bus.mem_wr_done = done;
      do_pop  = done && exp_q.size() != 0;
      do_push = push && (exp_q.size() < DEPTH || done);
      if (push && !do_push) exp_ovf = 1'b1;
      @(posedge clk);
      #1;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({a, s, d});
      idle_inputs();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      bus.mem_rd_addr = '0;
      bus.mem_rd_size = '0;
      exp_q.delete();
      exp_ovf = 1'b0;
      #1;
      n_total++;
      if (obs_vec() !== exp_vec())
         $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
      else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_fill();
      logic [31:0] addrs [5];
      addrs = '{32'h1000, 32'h1010, 32'h1020, 32'h1030, 32'h1040};
      for (int i = 0; i < 5; i++) begin
         step(1'b1, addrs[i], SZ_4B, {$urandom, $urandom}, 1'b0);
         n_total++;
         if (obs_vec() !== exp_vec())
            $display("FAIL fill_%0d: got %h want %h", i, obs_vec(), exp_vec());
         else n_pass++;
         if (i == 2) begin
            n_total++;
            if (bus.wr_fifo_to_be_full !== 1'b1)
               $display("FAIL fill_to_be_full: got %b want 1", bus.wr_fifo_to_be_full);
            else n_pass++;
         end
      end
      n_total++;
      if (bus.wr_fifo_ovf !== 1'b1 || bus.mem_wr_addr !== 32'h1000 || bus.dbg_count !== 3'd4)
         $display("FAIL fill_overflow: got ovf=%b head=%h cnt=%0d want ovf=1 head=1000 cnt=4",
                  bus.wr_fifo_ovf, bus.mem_wr_addr, bus.dbg_count);
      else n_pass++;
   endtask

   task automatic test_push_pop_full();
      step(1'b1, 32'h2000, SZ_8B, {$urandom, $urandom}, 1'b1);
      n_total++;
      if (obs_vec() !== exp_vec())
         $display("FAIL push_pop_full: got %h want %h", obs_vec(), exp_vec());
      else n_pass++;
      n_total++;
      if (bus.mem_wr_addr !== 32'h1010 || bus.dbg_count !== 3'd4)
         $display("FAIL push_pop_full_head: got head=%h cnt=%0d want head=1010 cnt=4",
                  bus.mem_wr_addr, bus.dbg_count);
      else n_pass++;
   endtask

   task automatic test_drain();
      while (exp_q.size() != 0) begin
         step(1'b0, '0, '0, '0, 1'b1);
         n_total++;
         if (obs_vec() !== exp_vec())
            $display("FAIL drain: got %h want %h", obs_vec(), exp_vec());
         else n_pass++;
      end
   endtask

   task automatic test_order_wrap();
      logic [31:0] a;
      for (int i = 0; i < 10; i++) begin
         a = $urandom;
         step(1'b1, a, 2'($urandom_range(0, 3)), {$urandom, $urandom}, 1'b0);
         n_total++;
         if (bus.mem_wr_addr !== a || obs_vec() !== exp_vec())
            $display("FAIL order_wrap_%0d: got %h want %h", i, obs_vec(), exp_vec());
         else n_pass++;
         step(1'b0, '0, '0, '0, 1'b1);
         n_total++;
         if (obs_vec() !== exp_vec())
            $display("FAIL order_wrap_pop_%0d: got %h want %h", i, obs_vec(), exp_vec());
         else n_pass++;
      end
   endtask

   task automatic test_conflict();
      logic [63:0] d;
      d = {$urandom, $urandom};
      bus.wb_push = 1'b1; bus.wb_addr = 32'h200C; bus.wb_size = SZ_8B; bus.wb_data = d;
      bus.mem_rd_addr = 32'h200C; bus.mem_rd_size = SZ_1B;
      #1;
      n_total++;
      if (bus.mem_conflict !== 1'b0)
         $display("FAIL conflict_same_cycle_push: got %b want 0", bus.mem_conflict);
      else n_pass++;
      step(1'b1, 32'h200C, SZ_8B, d, 1'b0);
      begin
         logic [31:0] la [4];
         logic [1:0]  ls [4];
         logic        ex [4];
         la = '{32'h2010, 32'h2020, 32'h2000, 32'h1FFF};
         ls = '{SZ_1B, SZ_1B, SZ_1B, SZ_2B};
         ex = '{1'b1, 1'b0, 1'b1, 1'b1};
         for (int i = 0; i < 4; i++) begin
            bus.mem_rd_addr = la[i];
            bus.mem_rd_size = ls[i];
            #1;
            n_total++;
            if (bus.mem_conflict !== ex[i])
               $display("FAIL conflict_load_%h: got %b want %b", la[i], bus.mem_conflict, ex[i]);
            else n_pass++;
         end
      end
      bus.mem_rd_addr = 32'h2010; bus.mem_rd_size = SZ_1B;
      bus.mem_wr_done = 1'b1;
      #1;
      n_total++;
      if (bus.mem_conflict !== 1'b1)
         $display("FAIL conflict_during_pop: got %b want 1", bus.mem_conflict);
      else n_pass++;
      step(1'b0, '0, '0, '0, 1'b1);
      n_total++;
      if (bus.mem_conflict !== 1'b0)
         $display("FAIL conflict_after_pop: got %b want 0", bus.mem_conflict);
      else n_pass++;
   endtask

   task automatic test_edge();
      step(1'b1, 32'hFFFF_FFFC, SZ_8B, {$urandom, $urandom}, 1'b0);
      bus.mem_rd_addr = 32'h0000_0000; bus.mem_rd_size = SZ_1B;
      #1;
      n_total++;
      if (bus.mem_conflict !== 1'b1)
         $display("FAIL edge_wrap_conflict: got %b want 1", bus.mem_conflict);
      else n_pass++;
      bus.mem_rd_addr = 32'h0000_0010;
      #1;
      n_total++;
      if (bus.mem_conflict !== 1'b0)
         $display("FAIL edge_wrap_noconflict: got %b want 0", bus.mem_conflict);
      else n_pass++;
      step(1'b0, '0, '0, '0, 1'b1);
      step(1'b0, '0, '0, '0, 1'b1);
      n_total++;
      if (bus.dbg_count !== 3'd0 || bus.wr_fifo_empty !== 1'b1 || obs_vec() !== exp_vec())
         $display("FAIL edge_pop_empty: got %h want %h", obs_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic test_random();
      logic        push;
      logic        done;
      logic [31:0] a;
      logic [1:0]  s;
      for (int i = 0; i < 60; i++) begin
         push = 1'($urandom_range(0, 1));
         done = ($urandom_range(0, 2) == 0);
         a    = 32'h3000 + $urandom_range(0, 127);
         s    = 2'($urandom_range(0, 3));
         bus.mem_rd_addr = 32'h3000 + $urandom_range(0, 127);
         bus.mem_rd_size = 2'($urandom_range(0, 3));
         bus.wb_push = push; bus.wb_addr = a; bus.wb_size = s; bus.mem_wr_done = done;
         #1;
         n_total++;
         if (bus.mem_conflict !== model_conflict(bus.mem_rd_addr, bus.mem_rd_size))
            $display("FAIL rand_conflict_%0d: got %b want %b", i, bus.mem_conflict,
                     model_conflict(bus.mem_rd_addr, bus.mem_rd_size));
         else n_pass++;
         step(push, a, s, {$urandom, $urandom}, done);
         n_total++;
         if (obs_vec() !== exp_vec())
            $display("FAIL rand_state_%0d: got %h want %h", i, obs_vec(), exp_vec());
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      while (exp_q.size() != 0) step(1'b0, '0, '0, '0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 32'h5000 + 32'(i * 16), SZ_4B, {$urandom, $urandom}, 1'b0);
      bus.mem_rd_addr = 32'h5000; bus.mem_rd_size = SZ_1B;
      #2;
      rst = 1'b1;
      #1;
      n_total++;
      if (bus.wr_fifo_empty !== 1'b1 || bus.wr_fifo_to_be_full !== 1'b0 ||
          bus.mem_conflict !== 1'b0 || bus.mem_wr_addr !== 32'h0 || bus.wr_fifo_ovf !== 1'b0)
         $display("FAIL reset_mid: got e=%b f=%b c=%b head=%h ovf=%b want e=1 f=0 c=0 head=0 ovf=0",
                  bus.wr_fifo_empty, bus.wr_fifo_to_be_full, bus.mem_conflict,
                  bus.mem_wr_addr, bus.wr_fifo_ovf);
      else n_pass++;
      exp_q.delete();
      exp_ovf = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.wb_push = 1'b1; bus.wb_addr = 32'h4000; bus.wb_size = SZ_2B;
      #1;
      n_total++;
      if (bus.wr_fifo_empty !== 1'b1 || bus.mem_wr_addr !== 32'h0)
         $display("FAIL no_bypass: got e=%b head=%h want e=1 head=0", bus.wr_fifo_empty, bus.mem_wr_addr);
      else n_pass++;
      step(1'b1, 32'h4000, SZ_2B, 64'hDEAD_BEEF_0123_4567, 1'b0);
      n_total++;
      if (bus.mem_wr_addr !== 32'h4000 || obs_vec() !== exp_vec())
         $display("FAIL push_latency: got %h want %h", obs_vec(), exp_vec());
      else n_pass++;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      test_reset();
      test_fill();
      test_push_pop_full();
      test_drain();
      test_order_wrap();
      test_conflict();
      test_edge();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
